// File: rtl/fft_pkg.sv
// Shared types and default sizing for the in-place radix-2 FFT address sequencer.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } fft_state_t;

  localparam int FFT_LOG2N  = 4;
  localparam int FFT_BF_LAT = 2;
  localparam int FFT_N_PTS  = 1 << FFT_LOG2N;
  localparam int FFT_N_BF   = FFT_N_PTS / 2;

endpackage

// File: rtl/fft_wb_delay.sv
// Write-back delay line: a shift register that matches the butterfly latency.
module fft_wb_delay
  import fft_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = FFT_BF_LAT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pipe <= '0;
    end else if (i_clr) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/fft_addr_seq.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT: read, twiddle and
// latency-matched write-back addresses, with a DRAIN gap between stages.
module fft_addr_seq
  import fft_pkg::*;
#(
  parameter int LOG2N  = FFT_LOG2N,
  parameter int BF_LAT = FFT_BF_LAT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic [LOG2N-1:0] o_stage,
  output logic             o_bf_valid,
  output logic [LOG2N-1:0] o_rd_addr_a,
  output logic [LOG2N-1:0] o_rd_addr_b,
  output logic [LOG2N-2:0] o_tw_addr,
  output logic             o_wr_en,
  output logic [LOG2N-1:0] o_wr_addr_a,
  output logic [LOG2N-1:0] o_wr_addr_b
);

  localparam int               JW      = LOG2N - 1;
  localparam int               CW      = 4;
  localparam int               N_BF    = (1 << LOG2N) / 2;
  localparam int               WB_W    = 1 + 2 * LOG2N;
  localparam logic [JW-1:0]    J_LAST  = JW'(N_BF - 1);
  localparam logic [LOG2N-1:0] S_LAST  = LOG2N'(LOG2N - 1);
  localparam logic [CW-1:0]    DR_LOAD = CW'(BF_LAT);

  fft_state_t       r_state;
  logic [JW-1:0]    r_j;
  logic [LOG2N-1:0] r_stage;
  logic [CW-1:0]    r_drain;
  logic             r_busy;
  logic             r_done;
  logic             r_bf_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_j        <= '0;
      r_stage    <= '0;
      r_drain    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bf_valid <= 1'b0;
    end else if (i_abort) begin
      r_state    <= ST_IDLE;
      r_j        <= '0;
      r_stage    <= '0;
      r_drain    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bf_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state    <= ST_RUN;
            r_j        <= '0;
            r_stage    <= '0;
            r_busy     <= 1'b1;
            r_bf_valid <= 1'b1;
          end
        end
        ST_RUN: begin
          if (r_j == J_LAST) begin
            r_state    <= ST_DRAIN;
            r_drain    <= DR_LOAD;
            r_bf_valid <= 1'b0;
          end else begin
            r_j <= r_j + JW'(1);
          end
        end
        // Hold off the next stage until the last write of this one has landed.
        ST_DRAIN: begin
          if (r_drain == CW'(1)) begin
            if (r_stage == S_LAST) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= ST_RUN;
              r_stage    <= r_stage + LOG2N'(1);
              r_j        <= '0;
              r_bf_valid <= 1'b1;
            end
          end else begin
            r_drain <= r_drain - CW'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_stage <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // half = 2**s; a = grp*2*half + pos, b = a + half, k = pos << (LOG2N-1-s)
  logic [LOG2N-1:0] w_j;
  logic [LOG2N-1:0] w_half;
  logic [LOG2N-1:0] w_pos;
  logic [LOG2N-1:0] w_grp;
  logic [LOG2N-1:0] w_a;
  logic [LOG2N-1:0] w_tw_sh;
  logic [LOG2N-2:0] w_tw;

  assign w_j     = {1'b0, r_j};
  assign w_half  = LOG2N'(1) << r_stage;
  assign w_pos   = w_j & (w_half - LOG2N'(1));
  assign w_grp   = w_j >> r_stage;
  assign w_a     = (w_grp << (r_stage + LOG2N'(1))) | w_pos;
  assign w_tw_sh = S_LAST - r_stage;
  assign w_tw    = w_pos[LOG2N-2:0] << w_tw_sh;

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_stage     = r_stage;
  assign o_bf_valid  = r_bf_valid;
  assign o_rd_addr_a = r_bf_valid ? w_a : '0;
  assign o_rd_addr_b = r_bf_valid ? (w_a | w_half) : '0;
  assign o_tw_addr   = r_bf_valid ? w_tw : '0;

  logic [WB_W-1:0] w_wb;

  fft_wb_delay #(
    .WIDTH(WB_W),
    .DEPTH(BF_LAT)
  ) u_wb_delay (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (i_abort),
    .i_d    ({r_bf_valid, o_rd_addr_a, o_rd_addr_b}),
    .o_q    (w_wb)
  );

  assign o_wr_en     = w_wb[WB_W-1];
  assign o_wr_addr_a = w_wb[2*LOG2N-1:LOG2N];
  assign o_wr_addr_b = w_wb[LOG2N-1:0];

endmodule

// File: tb/tb_fft_addr_seq.sv
// Directed bench for fft_addr_seq at N=16, BF_LAT=2; cycle 1 is the first cycle after start is taken.
module tb_fft_addr_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, bf_valid, wr_en;
  logic [3:0] stage, rd_a, rd_b, wr_a, wr_b;
  logic [2:0] tw;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  fft_addr_seq #(.LOG2N(4), .BF_LAT(2)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_abort    (abort),
    .o_busy     (busy),
    .o_done     (done),
    .o_stage    (stage),
    .o_bf_valid (bf_valid),
    .o_rd_addr_a(rd_a),
    .o_rd_addr_b(rd_b),
    .o_tw_addr  (tw),
    .o_wr_en    (wr_en),
    .o_wr_addr_a(wr_a),
    .o_wr_addr_b(wr_b)
  );

  // Hand-derived A addresses and twiddle indices per stage for N=16.
  localparam int EXP_A [4][8] = '{
    '{0, 2, 4, 6, 8, 10, 12, 14},
    '{0, 1, 4, 5, 8,  9, 12, 13},
    '{0, 1, 2, 3, 8,  9, 10, 11},
    '{0, 1, 2, 3, 4,  5,  6,  7}
  };
  localparam int EXP_TW [4][8] = '{
    '{0, 0, 0, 0, 0, 0, 0, 0},
    '{0, 4, 0, 4, 0, 4, 0, 4},
    '{0, 2, 4, 6, 0, 2, 4, 6},
    '{0, 1, 2, 3, 4, 5, 6, 7}
  };

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       bf;
    logic [3:0] stg;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] tw;
  } exp_t;

  function automatic exp_t exp_at(int c);
    exp_t e;
    int   p, k;
    e = '0;
    if (c >= 1 && c <= 40) begin
      p = (c - 1) / 10;
      k = (c - 1) % 10;
      e.stg = 4'(p);
      if (k < 8) begin
        e.bf = 1'b1;
        e.a  = 4'(EXP_A[p][k]);
        e.b  = e.a + 4'(1 << p);
        e.tw = 3'(EXP_TW[p][k]);
      end
    end
    if (c == 41) begin
      e.stg  = 4'd3;
      e.done = 1'b1;
    end
    e.busy = (c >= 1 && c <= 41);
    return e;
  endfunction

  function automatic exp_t cur();
    return {busy, done, bf_valid, stage, rd_a, rd_b, tw};
  endfunction

  function automatic logic [26:0] all_out();
    return {cur(), wr_en, wr_a, wr_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    tests++;
    if (all_out() !== 27'd0) begin
      fails++; $display("FAIL reset_async got=%h exp=0", all_out());
    end
    tick(); tick();
    tests++;
    if (all_out() !== 27'd0) begin
      fails++; $display("FAIL reset_held got=%h exp=0", all_out());
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (all_out() !== 27'd0) begin
      fails++; $display("FAIL reset_idle got=%h exp=0", all_out());
    end
  endtask

  task automatic test_full_transform();
    exp_t e;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 43; c++) begin
      e = exp_at(c);
      tests++;
      if (cur() !== e) begin
        fails++; $display("FAIL rd_seq cyc=%0d got=%h exp=%h", c, cur(), e);
      end
      tick();
    end
  endtask

  task automatic test_writeback();
    exp_t e;
    int   nwr;
    nwr = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 43; c++) begin
      e = exp_at(c - 2);
      tests++;
      if ({wr_en, wr_a, wr_b} !== {e.bf, e.a, e.b}) begin
        fails++; $display("FAIL wb_align cyc=%0d got=%h exp=%h", c, {wr_en, wr_a, wr_b}, {e.bf, e.a, e.b});
      end
      if (wr_en === 1'b1) nwr++;
      tests++;
      if (bf_valid === 1'b1 && nwr < 8 * int'(stage)) begin
        fails++; $display("FAIL raw_hazard cyc=%0d writes=%0d need=%0d", c, nwr, 8 * int'(stage));
      end
      tick();
    end
    tests++;
    if (nwr !== 32) begin
      fails++; $display("FAIL wr_count got=%0d exp=32", nwr);
    end
  endtask

  task automatic test_start_ignored();
    int   nd, dc;
    logic b41, b42;
    nd = 0; dc = -1; b41 = 1'b0; b42 = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      start = (c == 5 || c == 20);
      if (done === 1'b1) begin nd++; dc = c; end
      if (c == 41) b41 = busy;
      if (c == 42) b42 = busy;
      tick();
    end
    start = 1'b0;
    tests++;
    if (nd !== 1) begin fails++; $display("FAIL ign_done_count got=%0d exp=1", nd); end
    tests++;
    if (dc !== 41) begin fails++; $display("FAIL ign_done_cycle got=%0d exp=41", dc); end
    tests++;
    if ({b41, b42} !== 2'b10) begin fails++; $display("FAIL ign_busy_edge got=%b exp=10", {b41, b42}); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL ign_no_queue got=%b exp=0", busy); end
  endtask

  task automatic test_abort();
    int nd, dc, nwr;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      abort = (c == 15);
      if (c == 16) begin
        tests++;
        if (all_out() !== 27'd0) begin
          fails++; $display("FAIL abort_zero got=%h exp=0", all_out());
        end
      end
      if (c >= 16) begin
        tests++;
        if (wr_en !== 1'b0) begin
          fails++; $display("FAIL abort_wr cyc=%0d got=%b exp=0", c, wr_en);
        end
      end
      tick();
    end
    abort = 1'b0;
    nd = 0; dc = -1; nwr = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 43; c++) begin
      if (done === 1'b1) begin nd++; dc = c; end
      if (wr_en === 1'b1) nwr++;
      tick();
    end
    tests++;
    if (dc !== 41 || nd !== 1) begin
      fails++; $display("FAIL abort_restart done_cyc=%0d n=%0d exp=41/1", dc, nd);
    end
    tests++;
    if (nwr !== 32) begin fails++; $display("FAIL abort_restart_wr got=%0d exp=32", nwr); end
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1; abort = 1'b1; tick();
    start = 1'b0; abort = 1'b0;
    tests++;
    if (all_out() !== 27'd0) begin
      fails++; $display("FAIL start_abort_idle got=%h exp=0", all_out());
    end
    tick();
    tests++;
    if (busy !== 1'b0 || bf_valid !== 1'b0) begin
      fails++; $display("FAIL start_abort_noqueue got=%b%b exp=00", busy, bf_valid);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   dc, nwr;
    start = 1'b1; tick(); start = 1'b0;
    repeat (22) tick();
    e = exp_at(23);
    tests++;
    if (cur() !== e) begin
      fails++; $display("FAIL pre_reset cyc=23 got=%h exp=%h", cur(), e);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (all_out() !== 27'd0) begin
      fails++; $display("FAIL async_reset got=%h exp=0", all_out());
    end
    tick();
    rst_n = 1'b1;
    tick();
    dc = -1; nwr = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 43; c++) begin
      e = exp_at(c);
      tests++;
      if (cur() !== e) begin
        fails++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", c, cur(), e);
      end
      if (done === 1'b1) dc = c;
      if (wr_en === 1'b1) nwr++;
      tick();
    end
    tests++;
    if (dc !== 41 || nwr !== 32) begin
      fails++; $display("FAIL post_reset_run done_cyc=%0d wr=%0d exp=41/32", dc, nwr);
    end
  endtask

  initial begin
    test_reset();
    test_full_transform();
    test_writeback();
    test_start_ignored();
    test_abort();
    test_start_abort_idle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule

// File: doc/fft_addr_seq.md
Name: fft_addr_seq

Overview:
- Sequences one in-place radix-2 DIT FFT over a single-port-pair sample memory and one pipelined butterfly unit.
- Per stage, issues butterfly read addresses (A/B pair) and the twiddle ROM address.
- Drives the delayed write-back addresses and write enable for the butterfly results.
- Start/done handshake toward the top-level FFT controller. Input bit-reversal is handled upstream.

Parameters:
LOG2N, 4, log2 of transform size N; N = 2**LOG2N points, N/2 butterflies per stage, LOG2N stages.
BF_LAT, 2, butterfly pipeline latency in cycles from bf_valid to result valid; legal range 1..8.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request a transform; accepted only in IDLE.
abort  in  1  synchronous abort; returns to IDLE next edge, flushes pending writes.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse when the last write-back has been issued.
stage  out  LOG2N  current stage index s, 0..LOG2N-1 (excess width, upper bits zero).
bf_valid  out  1  rd_addr_a/rd_addr_b/tw_addr are valid this cycle.
rd_addr_a  out  LOG2N  upper butterfly input address.
rd_addr_b  out  LOG2N  lower butterfly input address.
tw_addr  out  LOG2N-1  twiddle ROM index k for W_N^k.
wr_en  out  1  write butterfly results this cycle.
wr_addr_a  out  LOG2N  write address for upper result (= rd_addr_a delayed BF_LAT).
wr_addr_b  out  LOG2N  write address for lower result (= rd_addr_b delayed BF_LAT).

Behaviour:
- Reset (rst_n low, async):
  - State goes to IDLE.
  - All outputs are 0, including the write-back delay line.
- FSM: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 -> RUN, with s=0 and j=0.
  - RUN: bf_valid=1 every cycle, and j increments.
    - At j=N/2-1 -> DRAIN, with drain counter = BF_LAT.
  - DRAIN: bf_valid=0; counts down BF_LAT cycles so the last writes of the stage land before the next stage reads them (RAW hazard).
    - At end: if s<LOG2N-1, s++, j=0 -> RUN; else -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Address arithmetic, with half = 2**s:
  - pos = j mod half
  - grp = j >> s
  - rd_addr_a = grp*2*half + pos
  - rd_addr_b = rd_addr_a + half
  - tw_addr = pos << (LOG2N-1-s)
  - All addresses are unsigned and never overflow LOG2N bits.
- Write-back:
  - wr_en, wr_addr_a and wr_addr_b are bf_valid, rd_addr_a and rd_addr_b delayed by exactly BF_LAT cycles.
  - The delay line is a shift register, cleared by reset or abort.
- Timing (N=16, BF_LAT=2, start accepted at edge 0):
  - bf_valid high for cycles 1..8 (s=0), 11..18, 21..28 and 31..38.
  - wr_en high for cycles 3..10, 13..20, etc.; last write at cycle 40.
  - done at cycle 41; busy high over 1..41.
  - Total = LOG2N*(N/2+BF_LAT)+1 cycles.
- busy falls in the cycle after done.
- Boundary conditions:
  - start while not IDLE: ignored, with no queuing.
  - start and abort in the same cycle in IDLE: abort wins and the state stays IDLE.
  - abort in any state: next edge state=IDLE, outputs zero, and no wr_en is issued afterwards.
  - rst_n asserted mid-transform: immediate IDLE; the memory contents are undefined to the caller.
  - The j counter wraps only via explicit reload, never by overflow.

Decomposition:
- Package fft_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - the default LOG2N and BF_LAT constants;
  - the derived N_PTS and N_BF = N_PTS/2.
- Sub-module fft_wb_delay: parameterised (WIDTH, DEPTH=BF_LAT) shift register with async active-low reset and synchronous clear. It carries {valid, addr_a, addr_b}.
- The address/twiddle math stays combinational inside fft_addr_seq.

Test Plan:
- Reset then start pulse, N=16, BF_LAT=2 -> addresses as follows, with done at cycle 41 and busy high over cycles 1..41:
  - stage 0 pairs (0,1),(2,3)..(14,15), tw_addr all 0;
  - stage 3 pairs (0,8),(1,9)..(7,15), tw_addr 0..7.
- Stage 1 check -> pairs (0,2),(1,3),(4,6),(5,7)..., tw_addr sequence 0,4,0,4,...
- Write-back alignment -> every wr_addr_a/wr_addr_b equals the rd_addr pair seen 2 cycles earlier; wr_en count = 32 per transform; no bf_valid of stage s+1 before the last wr_en of stage s.
- start pulsed at cycles 5 and 20 while busy -> ignored; a single done at cycle 41.
- abort at cycle 15 -> cycle 16 state IDLE, all outputs 0, no wr_en after cycle 16; a new start then completes normally in 41 cycles.
- rst_n low asynchronously at cycle 23 (between edges) -> outputs 0 immediately; a subsequent start runs a full transform.
